// File: rtl/fft_lane_packer.sv
// Serial-to-parallel I/Q packer: collects NUM samples per block into ping-pong
// banks and presents each completed bank as a parallel lane vector.
module fft_lane_packer #(
  parameter int IN_WIDTH = 15,
  parameter int NUM      = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic signed [IN_WIDTH-1:0] din_i,
  input  logic signed [IN_WIDTH-1:0] din_q,
  input  logic                       valid_in,
  input  logic                       sop_in,
  output logic                       in_ready,
  output logic signed [IN_WIDTH-1:0] dout_i [0:NUM-1],
  output logic signed [IN_WIDTH-1:0] dout_q [0:NUM-1],
  output logic                       valid_out,
  input  logic                       out_ready,
  output logic                       sop_err
);

  localparam int CW = $clog2(NUM);

  logic signed [IN_WIDTH-1:0] bank_i [0:1][0:NUM-1];
  logic signed [IN_WIDTH-1:0] bank_q [0:1][0:NUM-1];
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] fill_cnt, fill_nxt, lane;
  logic          accept, xfer, trunc, last;

  assign in_ready  = ~full[wr_bank];
  assign valid_out = full[rd_bank];

  always_comb begin
    for (int unsigned k = 0; k < NUM; k++) begin
      dout_i[k] = bank_i[rd_bank][k];
      dout_q[k] = bank_q[rd_bank][k];
    end
  end

  always_comb begin
    accept   = valid_in & in_ready;
    xfer     = valid_out & out_ready;
    trunc    = accept & sop_in & (fill_cnt != '0);
    last     = accept & ~trunc & (fill_cnt == CW'(NUM-1));
    lane     = trunc ? '0 : fill_cnt;
    fill_nxt = fill_cnt;
    if (trunc)
      fill_nxt = CW'(1);
    else if (accept)
      fill_nxt = fill_cnt + 1'b1;
    // A completing bank and a drained bank are never the same bank: completion
    // needs full[wr_bank]=0 while a transfer needs full[rd_bank]=1.
    full_nxt = full;
    if (last) full_nxt[wr_bank] = 1'b1;
    if (xfer) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned k = 0; k < NUM; k++) begin
          bank_i[b][k] <= '0;
          bank_q[b][k] <= '0;
        end
      end
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      fill_cnt <= '0;
      sop_err  <= 1'b0;
    end else begin
      if (accept) begin
        bank_i[wr_bank][lane] <= din_i;
        bank_q[wr_bank][lane] <= din_q;
      end
      fill_cnt <= fill_nxt;
      full     <= full_nxt;
      sop_err  <= trunc;
      if (last) wr_bank <= ~wr_bank;
      if (xfer) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_fft_lane_packer.sv
// Directed self-checking bench for fft_lane_packer (IN_WIDTH=15, NUM=16).
module tb_fft_lane_packer;

  localparam int W = 15;
  localparam int N = 16;

  logic                clk = 1'b0;
  logic                rstn;
  logic signed [W-1:0] din_i, din_q;
  logic                valid_in, sop_in;
  logic                in_ready;
  logic signed [W-1:0] dout_i [0:N-1];
  logic signed [W-1:0] dout_q [0:N-1];
  logic                valid_out;
  logic                out_ready;
  logic                sop_err;

  int n_checks = 0;
  int n_fail   = 0;

  fft_lane_packer #(.IN_WIDTH(W), .NUM(N)) dut (
    .clk(clk), .rstn(rstn),
    .din_i(din_i), .din_q(din_q),
    .valid_in(valid_in), .sop_in(sop_in),
    .in_ready(in_ready),
    .dout_i(dout_i), .dout_q(dout_q),
    .valid_out(valid_out), .out_ready(out_ready),
    .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic s, input int i, input int q);
    valid_in = v;
    sop_in   = s;
    din_i    = W'(i);
    din_q    = W'(q);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_in(1'b0, 1'b0, 0, 0);
    out_ready = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_in(1'b0, 1'b0, 0, 0);
    out_ready = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    n_checks++;
    if (sop_err !== 1'b0) begin n_fail++; $display("FAIL reset_sop_err got=%b exp=0", sop_err); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== '0 || dout_q[k] !== '0) begin
        n_fail++; $display("FAIL reset_dout lane=%0d got=%0d/%0d exp=0/0", k, dout_i[k], dout_q[k]);
      end
    end
    step();
    rstn = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_fill();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_in(1'b1, k == 0, k, -k);
      step();
      if (k == N-2) begin
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", valid_out); end
      end
    end
    set_in(1'b0, 1'b0, 0, 0);
    n_checks++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", valid_out); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== W'(k) || dout_q[k] !== W'(-k)) begin
        n_fail++; $display("FAIL basic_lane lane=%0d got=%0d/%0d exp=%0d/%0d", k, dout_i[k], dout_q[k], k, -k);
      end
    end
    step();
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", valid_out); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 2*N; k++) begin
      set_in(1'b1, (k % N) == 0, k, -k);
      step();
      if (k == N-1 || k == 2*N-2) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_mid k=%0d got=%b exp=1", k, in_ready); end
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop got=%b exp=0", in_ready); end
    set_in(1'b1, 1'b0, 999, 999);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (valid_out !== 1'b1 || in_ready !== 1'b0 || dout_i[0] !== W'(0) || dout_i[N-1] !== W'(N-1)
          || dout_q[N-1] !== W'(-(N-1))) begin
        n_fail++;
        $display("FAIL bp_stable c=%0d got v=%b r=%b i0=%0d i15=%0d q15=%0d exp v=1 r=0 i0=0 i15=%0d q15=%0d",
                 c, valid_out, in_ready, dout_i[0], dout_i[N-1], dout_q[N-1], N-1, -(N-1));
      end
    end
    set_in(1'b0, 1'b0, 0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_recover got=%b exp=1", in_ready); end
    n_checks++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid got=%b exp=1", valid_out); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== W'(N+k) || dout_q[k] !== W'(-(N+k))) begin
        n_fail++; $display("FAIL bp_second_lane lane=%0d got=%0d/%0d exp=%0d/%0d", k, dout_i[k], dout_q[k], N+k, -(N+k));
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", valid_out); end
  endtask

  task automatic test_streaming();
    int drops  = 0;
    int pulses = 0;
    int last_c = 0;
    out_ready = 1'b1;
    for (int c = 1; c <= 4*N + 4; c++) begin
      if (c <= 4*N) set_in(1'b1, ((c-1) % N) == 0, 300 + c - 1, -(c - 1));
      else          set_in(1'b0, 1'b0, 0, 0);
      step();
      if (in_ready !== 1'b1) drops++;
      if (valid_out === 1'b1) begin
        n_checks++;
        if (c != (pulses + 1) * N || dout_i[0] !== W'(300 + pulses*N) || dout_i[N-1] !== W'(300 + pulses*N + N-1)) begin
          n_fail++;
          $display("FAIL stream_pulse idx=%0d got cyc=%0d i0=%0d i15=%0d exp cyc=%0d i0=%0d i15=%0d (prev=%0d)",
                   pulses, c, dout_i[0], dout_i[N-1], (pulses+1)*N, 300 + pulses*N, 300 + pulses*N + N-1, last_c);
        end
        pulses++;
        last_c = c;
      end
    end
    n_checks++;
    if (drops != 0) begin n_fail++; $display("FAIL stream_ready_drops got=%0d exp=0", drops); end
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL stream_pulses got=%0d exp=4", pulses); end
  endtask

  task automatic test_sop_trunc();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, k == 0, 50 + k, 0);
      step();
      n_checks++;
      if (sop_err !== 1'b0) begin n_fail++; $display("FAIL sop_no_err k=%0d got=%b exp=0", k, sop_err); end
    end
    set_in(1'b1, 1'b1, 100, -100);
    step();
    n_checks++;
    if (sop_err !== 1'b1) begin n_fail++; $display("FAIL sop_err_pulse got=%b exp=1", sop_err); end
    for (int k = 1; k < N; k++) begin
      set_in(1'b1, 1'b0, 100 + k, -(100 + k));
      step();
      if (k == 1) begin
        n_checks++;
        if (sop_err !== 1'b0) begin n_fail++; $display("FAIL sop_err_one_cycle got=%b exp=0", sop_err); end
      end
      if (k == N-2) begin
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL sop_early_valid got=%b exp=0", valid_out); end
      end
    end
    set_in(1'b0, 1'b0, 0, 0);
    n_checks++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL sop_valid got=%b exp=1", valid_out); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== W'(100 + k) || dout_q[k] !== W'(-(100 + k))) begin
        n_fail++; $display("FAIL sop_lane lane=%0d got=%0d/%0d exp=%0d/%0d", k, dout_i[k], dout_q[k], 100+k, -(100+k));
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < N + 10; k++) begin
      set_in(1'b1, (k % N) == 0, 700 + k, 1);
      step();
    end
    set_in(1'b0, 1'b0, 0, 0);
    n_checks++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got=%b exp=1", valid_out); end
    rstn = 1'b0;
    #2;
    n_checks++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1 || sop_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctrl got v=%b r=%b e=%b exp v=0 r=1 e=0", valid_out, in_ready, sop_err);
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== '0 || dout_q[k] !== '0) begin
        n_fail++; $display("FAIL rmid_dout lane=%0d got=%0d/%0d exp=0/0", k, dout_i[k], dout_q[k]);
      end
    end
    step();
    rstn = 1'b1;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_in(1'b1, k == 0, 400 + k, -(400 + k));
      step();
    end
    set_in(1'b0, 1'b0, 0, 0);
    n_checks++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_valid got=%b exp=1", valid_out); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== W'(400 + k) || dout_q[k] !== W'(-(400 + k))) begin
        n_fail++; $display("FAIL rmid_lane lane=%0d got=%0d/%0d exp=%0d/%0d", k, dout_i[k], dout_q[k], 400+k, -(400+k));
      end
    end
    step();
  endtask

  task automatic test_boundary();
    do_reset();
    for (int k = 0; k < 2*N; k++) begin
      set_in(1'b1, (k % N) == 0, 500 + k, -(500 + k));
      if (k == 2*N-1) begin
        n_checks++;
        if (valid_out !== 1'b1 || dout_i[0] !== W'(500)) begin
          n_fail++; $display("FAIL bnd_bank0 got v=%b i0=%0d exp v=1 i0=500", valid_out, dout_i[0]);
        end
        out_ready = 1'b1;
      end
      step();
    end
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 0, 0);
    n_checks++;
    if (valid_out !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bnd_ctrl got v=%b r=%b exp v=1 r=1", valid_out, in_ready);
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (dout_i[k] !== W'(500 + N + k) || dout_q[k] !== W'(-(500 + N + k))) begin
        n_fail++; $display("FAIL bnd_lane lane=%0d got=%0d/%0d exp=%0d/%0d", k, dout_i[k], dout_q[k], 500+N+k, -(500+N+k));
      end
    end
    step();
    n_checks++;
    if (valid_out !== 1'b1 || dout_i[N-1] !== W'(500 + 2*N - 1)) begin
      n_fail++; $display("FAIL bnd_hold got v=%b i15=%0d exp v=1 i15=%0d", valid_out, dout_i[N-1], 500 + 2*N - 1);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bnd_drain got=%b exp=0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_streaming();
    test_sop_trunc();
    test_reset_mid();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_lane_packer.md
FFT_LANE_PACKER -- requirements
Module: fft_lane_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 15, signed sample width of the I and Q components.
REQ-002 SHALL have parameter NUM, default 16, lanes per output block (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port din_i, input, signed [IN_WIDTH], serial Re sample.
REQ-006 SHALL have port din_q, input, signed [IN_WIDTH], serial Im sample.
REQ-007 SHALL have port valid_in, input, 1, serial sample valid.
REQ-008 SHALL have port sop_in, input, 1, start of block; qualified by valid_in.
REQ-009 SHALL have port in_ready, output, 1, packer can accept a sample this cycle.
REQ-010 SHALL have port dout_i, output, signed [IN_WIDTH] x [0:NUM-1], packed Re lanes for the butterfly input.
REQ-011 SHALL have port dout_q, output, signed [IN_WIDTH] x [0:NUM-1], packed Im lanes.
REQ-012 SHALL have port valid_out, output, 1, a complete block is presented on dout_i/dout_q.
REQ-013 SHALL have port out_ready, input, 1, the downstream stage takes the presented block.
REQ-014 SHALL have port sop_err, output, 1, one-cycle pulse when sop_in truncates a partial block.

Function
REQ-015 SHALL hold two banks (ping-pong), each NUM lanes of I/Q, a full flag per bank, wr_bank and rd_bank pointers, and a fill counter of width log2(NUM).
REQ-016 SHALL accept a sample when valid_in and in_ready are both high; no other sample SHALL alter state.
REQ-017 SHALL drive in_ready = NOT full[wr_bank], from registers only; no combinational path from out_ready or valid_in.
REQ-018 SHALL write each accepted sample to lane fill_cnt of wr_bank, then increment fill_cnt.
REQ-019 SHALL, on acceptance with fill_cnt = NUM-1: set full[wr_bank], toggle wr_bank, and wrap fill_cnt to 0.
REQ-020 SHALL treat an accepted sample with sop_in=1 and fill_cnt != 0 as follows: discard the partial block, write the sample to lane 0 of the same bank, set fill_cnt to 1, and pulse sop_err the next cycle.
REQ-021 SHALL treat an accepted sample with sop_in=1 and fill_cnt = 0 as normal, with no sop_err.
REQ-022 SHALL drive valid_out = full[rd_bank], and drive dout_i/dout_q directly from the rd_bank registers.
REQ-023 SHALL complete the output transfer when valid_out and out_ready are both high: clear full[rd_bank] and toggle rd_bank.
REQ-024 SHALL keep dout_i/dout_q and valid_out stable while valid_out=1 and out_ready=0.
REQ-025 SHALL assert valid_out in cycle t+1 when the last lane is accepted in cycle t and the read bank was empty.
REQ-026 SHALL apply a bank-complete and an output transfer in the same cycle, both effective.
REQ-027 SHALL sustain 1 sample per cycle indefinitely when out_ready is high at least once per NUM cycles.
REQ-028 SHALL pass data unmodified (no rounding or saturation), with lane k holding the k-th accepted sample of the block.

Reset
REQ-029 SHALL, on rstn low, immediately clear: both full flags, wr_bank, rd_bank, fill_cnt, sop_err, valid_out, and all bank lanes (so dout_i and dout_q are 0).
REQ-030 SHALL drive in_ready=1 during and after reset.
REQ-031 SHALL discard any partial or full block held when reset is asserted mid-operation.

Verification
REQ-032 SHALL cover basic fill: 16 samples i=k, q=-k, out_ready=1 -> valid_out one cycle after the 16th sample; dout_i[k]=k, dout_q[k]=-k.
REQ-033 SHALL cover backpressure: out_ready=0 while 32 samples are offered -> in_ready falls after the 32nd acceptance; outputs stay stable; out_ready=1 for 1 cycle -> in_ready=1 the next cycle, and the second block (samples 16..31) is presented.
REQ-034 SHALL cover streaming: 64 contiguous valid samples with out_ready=1 -> in_ready never drops; 4 valid_out pulses 16 cycles apart.
REQ-035 SHALL cover sop truncation: 5 samples, then sop_in with value 100 -> sop_err pulse; the block emitted after 15 more samples has dout_i[0]=100.
REQ-036 SHALL cover reset mid-block: rstn low after 10 samples -> all outputs 0 and in_ready=1; the next 16 samples form a clean block in lanes 0..15.
REQ-037 SHALL cover the boundary case: bank 1 completes in the same cycle bank 0 is drained -> no sample is lost and valid_out stays high presenting bank 1.
